aes_core_arbiter: RTL and testbench
===================================

# aes_core_arbiter

Round-robin scheduler that shares one AES core (the `aes_fsm_gen` control FSM plus its datapath) among `NREQ` requesters. It accepts one job at a time over per-requester valid/ready handshakes and drives the core's `start`, `mode` and `enc_dec` inputs. It waits for the core's `done`, with a watchdog, and returns a tagged completion response. Datapath muxing of key, plaintext and ciphertext is steered externally by `grant_id`.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `ID_W`, 2: width of requester index, `$clog2(NREQ)`.
- `TIMEOUT`, 48: maximum cycles in WAIT before the job is aborted; must be at least 32.
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-high.
- `req_valid`  in  NREQ  per-requester job request; the requester holds it until accepted.
- `req_mode`  in  2*NREQ  per-requester key size; slice i is `[2i+1:2i]`; 00=128, 01=192, 10=256, 11=illegal.
- `req_enc_dec`  in  NREQ  per-requester direction; 0=encrypt, 1=decrypt.
- `req_ready`  out  NREQ  one-hot accept strobe.
- `core_start`  out  1  single-cycle start pulse to the core.
- `core_mode`  out  2  registered mode; stable from ISSUE through WAIT.
- `core_enc_dec`  out  1  registered direction; stable from ISSUE through WAIT.
- `core_done`  in  1  completion from the core.
- `grant_id`  out  ID_W  index of the requester that owns the core.
- `busy`  out  1  high in every state except IDLE.
- `resp_valid`  out  1  completion available.
- `resp_id`  out  ID_W  requester index of the completion.
- `resp_err`  out  1  1 = timeout or illegal mode.
- `resp_ready`  in  1  completion consumer ready.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid` is high, select the first requester in priority order `last+1, last+2, … last+NREQ` (mod NREQ).
  - Assert `req_ready` combinationally for that requester only.
  - On the next edge, latch `grant_id`, `core_mode` and `core_enc_dec`.
  - If the latched mode is 11, go to RESP with error=1 and never start the core. Otherwise go to ISSUE.
- **ISSUE**
  - `core_start`=1 for exactly this cycle.
  - Clear the timer and go to WAIT.
- **WAIT**
  - The timer increments each cycle.
  - On `core_done`=1, go to RESP with error=0.
  - Else, when the timer reaches `TIMEOUT`-1, go to RESP with error=1.
  - If `core_done` arrives in the same cycle the timer limit is reached, `core_done` wins and error=0.
- **RESP**
  - `resp_valid`=1 with `resp_id`=`grant_id` and `resp_err` registered.
  - `resp_valid`, `resp_id` and `resp_err` hold until `resp_ready`=1.
  - On that edge, set `last`=`grant_id` and go to IDLE.
- `core_done` is ignored outside WAIT.
- `req_valid` changes outside IDLE have no effect; no request is queued internally.
- `core_mode` and `core_enc_dec` keep their last values in IDLE and RESP.
- The timer is `$clog2(TIMEOUT)` bits and saturates; it never wraps.

## Timing
- Reset values:
  - state IDLE.
  - `last`=NREQ-1, so requester 0 has highest priority after reset.
  - `req_ready`=0, `core_start`=0, `core_mode`=00, `core_enc_dec`=0, `grant_id`=0.
  - `busy`=0, `resp_valid`=0, `resp_id`=0, `resp_err`=0.
- Reset asserted mid-job returns to IDLE immediately and drops the job without a response. The core is reset by the same `reset`.
- Accept at cycle t (`req_valid` & `req_ready`). Then `core_start` is high at t+1 and `busy` rises at t+1.
- `core_done` at cycle d gives `resp_valid` at d+1.
- A new accept is possible at the earliest in the cycle after the `resp_valid`/`resp_ready` handshake. Back-to-back jobs therefore have a minimum 1 idle cycle between them.
- Illegal mode: accept at t, `resp_valid`=1 at t+1 with `resp_err`=1, and `core_start` never pulses.
- Timeout: with no `core_done`, `resp_valid` rises `TIMEOUT`+1 cycles after `core_start`.

## Test plan
- **Single request:** requester 2 with mode 00 and encrypt; the core model returns `core_done` 10 cycles after start. Expect `req_ready`=0100, one `core_start` pulse, `core_mode`=00, then `resp_valid` with `resp_id`=2 and `resp_err`=0 exactly one cycle after `core_done`.
- **Round-robin fairness:** all four `req_valid` held high and `resp_ready` tied to 1. Expect grant order 0,1,2,3,0; no requester granted twice while another is waiting.
- **Watchdog:** requester 1 with mode 10 and decrypt; the core model never asserts done. Expect `resp_err`=1, `resp_id`=1, and `resp_valid` 49 cycles after `core_start`. A following job proceeds normally.
- **Illegal mode:** requester 3 with `req_mode`=11. Expect `core_start` to stay 0, `resp_valid` one cycle after accept, and `resp_err`=1.
- **Backpressure:** `resp_ready`=0 for 20 cycles after `core_done` while requester 0 is pending. Expect `resp_*` to hold stable, no new `req_ready`, and `core_start` to stay 0. Requester 0 is accepted the cycle after `resp_ready` rises.
- **Async reset mid-WAIT:** `reset` pulsed between clock edges during WAIT. Expect all outputs to return to their reset values immediately, with no `resp_valid` for the dropped job. A subsequent request from requester 3 completes normally while requester 0 has priority.

Source files
------------

// File: rtl/aes_core_arbiter_if.sv
// Requester, core-control and completion signals shared by the AES core arbiter.
interface aes_core_arbiter_if #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
);
   logic [NREQ-1:0]   req_valid;
   logic [2*NREQ-1:0] req_mode;
   logic [NREQ-1:0]   req_enc_dec;
   logic [NREQ-1:0]   req_ready;
   logic              core_start;
   logic [1:0]        core_mode;
   logic              core_enc_dec;
   logic              core_done;
   logic [ID_W-1:0]   grant_id;
   logic              busy;
   logic              resp_valid;
   logic [ID_W-1:0]   resp_id;
   logic              resp_err;
   logic              resp_ready;

   modport slave (
      input  req_valid, req_mode, req_enc_dec, core_done, resp_ready,
      output req_ready, core_start, core_mode, core_enc_dec, grant_id, busy,
             resp_valid, resp_id, resp_err
   );

   modport master (
      output req_valid, req_mode, req_enc_dec, core_done, resp_ready,
      input  req_ready, core_start, core_mode, core_enc_dec, grant_id, busy,
             resp_valid, resp_id, resp_err
   );
endinterface

// File: rtl/aes_core_arbiter.sv
// Round-robin scheduler sharing one AES core among NREQ requesters, with a
// watchdog on the core's done and a tagged completion response.
//
// state | meaning
// IDLE  | no job; grant the next valid requester after `last`
// ISSUE | one-cycle core_start pulse, watchdog timer cleared
// WAIT  | waiting for core_done or watchdog expiry
// RESP  | completion held until resp_ready
module aes_core_arbiter #(
   parameter int NREQ    = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 48
) (
   input  logic              clk,
   input  logic              reset,
   aes_core_arbiter_if.slave bus
);
   localparam int TMR_W = $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [TMR_W-1:0] TMR_MAX  = '1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t           state_q, state_nx;
   logic [ID_W-1:0]  grant_q, grant_nx;
   logic [ID_W-1:0]  last_q, last_nx;
   logic [1:0]       mode_q, mode_nx;
   logic             ed_q, ed_nx;
   logic             err_q, err_nx;
   logic [TMR_W-1:0] tmr_q, tmr_nx;

   logic             found;
   logic [ID_W-1:0]  sel;
   logic [1:0]       sel_mode;
   logic             sel_ed;
   int               cand;

   // Search last+1 .. last+NREQ (mod NREQ) for the first pending requester.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = 0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = int'(last_q) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         if (!found && (|(bus.req_valid & (NREQ'(1) << cand)))) begin
            found = 1'b1;
            sel   = ID_W'(cand);
         end
      end
      sel_mode = 2'(bus.req_mode >> {sel, 1'b0});
      sel_ed   = |(bus.req_enc_dec & (NREQ'(1) << sel));
   end

   always_comb begin
      state_nx      = state_q;
      grant_nx      = grant_q;
      last_nx       = last_q;
      mode_nx       = mode_q;
      ed_nx         = ed_q;
      err_nx        = err_q;
      tmr_nx        = tmr_q;
      bus.req_ready = '0;
      unique case (state_q)
         IDLE: begin
            if (found && !reset) begin
               bus.req_ready = NREQ'(1) << sel;
               grant_nx      = sel;
               mode_nx       = sel_mode;
               ed_nx         = sel_ed;
               // Illegal key size is answered directly; the core never starts.
               if (sel_mode == 2'b11) begin
                  err_nx   = 1'b1;
                  state_nx = RESP;
               end else begin
                  err_nx   = 1'b0;
                  state_nx = ISSUE;
               end
            end
         end
         ISSUE: begin
            tmr_nx   = '0;
            state_nx = WAIT;
         end
         WAIT: begin
            if (bus.core_done) begin
               err_nx   = 1'b0;
               state_nx = RESP;
            end else if (tmr_q == TMR_LAST) begin
               err_nx   = 1'b1;
               state_nx = RESP;
            end else if (tmr_q != TMR_MAX) begin
               tmr_nx = tmr_q + TMR_W'(1);
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               last_nx  = grant_q;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= ID_W'(NREQ - 1);
         mode_q  <= 2'b00;
         ed_q    <= 1'b0;
         err_q   <= 1'b0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_nx;
         grant_q <= grant_nx;
         last_q  <= last_nx;
         mode_q  <= mode_nx;
         ed_q    <= ed_nx;
         err_q   <= err_nx;
         tmr_q   <= tmr_nx;
      end
   end

   assign bus.core_start   = (state_q == ISSUE);
   assign bus.core_mode    = mode_q;
   assign bus.core_enc_dec = ed_q;
   assign bus.grant_id     = grant_q;
   assign bus.busy         = (state_q != IDLE);
   assign bus.resp_valid   = (state_q == RESP);
   assign bus.resp_id      = grant_q;
   assign bus.resp_err     = err_q;
endmodule

// File: tb/tb_aes_core_arbiter.sv
// Scoreboard bench for aes_core_arbiter: directed scenarios plus random jobs
// checked against a cycle-level reference of the scheduling and watchdog rules.
module tb_aes_core_arbiter;
   localparam int NREQ    = 4;
   localparam int ID_W    = 2;
   localparam int TIMEOUT = 48;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   aes_core_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

   aes_core_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec  = 0;
   int n_fail = 0;

   typedef struct { int id; int err; int rcyc; int mode; int ed; } exp_t;
   typedef struct { int id; int mode; int ed; int lat; } post_t;

   exp_t  exp_q[$];
   post_t post_q[$];
   int    grant_log[$];

   int              r_mode[NREQ];
   int              r_ed[NREQ];
   int              r_lat[NREQ];
   logic [NREQ-1:0] pend    = '0;
   logic [NREQ-1:0] sticky  = '0;
   logic [NREQ-1:0] acc_vec = '0;
   logic            rr_fixed = 1'b1;
   logic            rr_rand  = 1'b0;

   // reference-model state (owned by the monitor)
   int   model_busy    = 0;
   int   model_last    = NREQ - 1;
   int   exp_start_cyc = -1;
   int   cur_lat       = 0;
   logic prev_rv       = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_vec++;
      n_fail++;
      $display("FAIL %s: bound expired, got timeout, expected completion (cycle %0d)", name, cyc);
   endtask

   task automatic post(input int id, input int mode, input int ed, input int lat);
      post_t p;
      p.id = id; p.mode = mode; p.ed = ed; p.lat = lat;
      post_q.push_back(p);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"},  int'(bus.req_ready), 0);
      check({tag, "_core_start"}, int'(bus.core_start), 0);
      check({tag, "_core_mode"},  int'(bus.core_mode), 0);
      check({tag, "_core_ed"},    int'(bus.core_enc_dec), 0);
      check({tag, "_grant_id"},   int'(bus.grant_id), 0);
      check({tag, "_busy"},       int'(bus.busy), 0);
      check({tag, "_resp_valid"}, int'(bus.resp_valid), 0);
      check({tag, "_resp_id"},    int'(bus.resp_id), 0);
      check({tag, "_resp_err"},   int'(bus.resp_err), 0);
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while (!(pend == '0 && post_q.size() == 0 && exp_q.size() == 0 &&
               model_busy == 0 && !bus.busy) && n < budget) begin
         @(posedge clk); #2;
         n++;
      end
      if (n >= budget) fail_now(name);
   endtask

   // Requesters: hold req_valid until accepted (sticky ones re-request at once).
   initial begin
      post_t p;
      bus.req_valid   = '0;
      bus.req_mode    = '0;
      bus.req_enc_dec = '0;
      bus.resp_ready  = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         r_mode[i] = 0; r_ed[i] = 0; r_lat[i] = 0;
      end
      forever begin
         @(posedge clk); #1;
         pend = pend & ~(acc_vec & ~sticky);
         while (post_q.size() > 0) begin
            p = post_q.pop_front();
            pend[ID_W'(p.id)] = 1'b1;
            r_mode[p.id] = p.mode;
            r_ed[p.id]   = p.ed;
            r_lat[p.id]  = p.lat;
         end
         for (int i = 0; i < NREQ; i++) begin
            bus.req_mode[2*i +: 2] = 2'(r_mode[i]);
            bus.req_enc_dec[i]     = 1'(r_ed[i]);
         end
         bus.req_valid  = pend;
         bus.resp_ready = rr_rand ? ($urandom_range(0, 3) != 0) : rr_fixed;
      end
   end

   // Core model: raises core_done `lat` cycles after start (lat 0 = never).
   initial begin
      int   done_at;
      logic armed;
      logic prev_start;
      done_at = 0; armed = 1'b0; prev_start = 1'b0;
      bus.core_done = 1'b0;
      forever begin
         @(posedge clk); #1;
         bus.core_done = 1'b0;
         if (armed && cyc == done_at) begin
            bus.core_done = 1'b1;
            armed = 1'b0;
         end
         if (bus.core_start) begin
            check("core_start_cycle", cyc, exp_start_cyc);
            check("core_start_width", int'(prev_start), 0);
            if (exp_q.size() > 0) begin
               check("core_mode_at_start", int'(bus.core_mode), exp_q[exp_q.size()-1].mode);
               check("core_ed_at_start", int'(bus.core_enc_dec), exp_q[exp_q.size()-1].ed);
            end
            armed   = (cur_lat != 0);
            done_at = cyc + cur_lat;
         end
         prev_start = bus.core_start;
      end
   end

   // Monitor / reference model: predicts grants and completions from the rules.
   initial begin
      exp_t            e;
      exp_t            hold;
      logic [NREQ-1:0] exp_rdy;
      int              pick, j, lat, eff;
      hold = '{default: 0};
      forever begin
         @(negedge clk);
         if (reset) begin
            exp_q.delete();
            model_busy    = 0;
            model_last    = NREQ - 1;
            exp_start_cyc = -1;
            acc_vec       = '0;
            prev_rv       = 1'b0;
         end else begin
            exp_rdy = '0;
            pick    = -1;
            if (model_busy == 0) begin
               for (int k = 1; k <= NREQ; k++) begin
                  j = (model_last + k) % NREQ;
                  if (pick < 0 && bus.req_valid[ID_W'(j)]) pick = j;
               end
            end
            if (pick >= 0) exp_rdy[ID_W'(pick)] = 1'b1;
            if (exp_rdy != '0 || bus.req_ready != '0)
               check("req_ready", int'(bus.req_ready), int'(exp_rdy));
            for (int i = 0; i < NREQ; i++)
               if (bus.req_ready[i]) grant_log.push_back(i);
            acc_vec = bus.req_ready & bus.req_valid;
            if (pick >= 0 && bus.req_ready == exp_rdy) begin
               model_busy = 1;
               lat    = r_lat[pick];
               e.id   = pick;
               e.mode = r_mode[pick];
               e.ed   = r_ed[pick];
               if (e.mode == 3) begin
                  e.err = 1;
                  e.rcyc = cyc + 1;
                  exp_start_cyc = -1;
               end else begin
                  eff = (lat == 0 || lat > TIMEOUT) ? TIMEOUT : lat;
                  e.err = (lat == 0 || lat > TIMEOUT) ? 1 : 0;
                  e.rcyc = cyc + 2 + eff;
                  exp_start_cyc = cyc + 1;
                  cur_lat = lat;
               end
               exp_q.push_back(e);
            end
            if (bus.resp_valid) begin
               if (!prev_rv) begin
                  if (exp_q.size() == 0) begin
                     check("resp_unexpected", int'(bus.resp_valid), 0);
                  end else begin
                     hold = exp_q.pop_front();
                     check("resp_id",      int'(bus.resp_id), hold.id);
                     check("resp_err",     int'(bus.resp_err), hold.err);
                     check("resp_cycle",   cyc, hold.rcyc);
                     check("resp_mode",    int'(bus.core_mode), hold.mode);
                     check("resp_enc_dec", int'(bus.core_enc_dec), hold.ed);
                  end
               end else begin
                  check("resp_id_hold",  int'(bus.resp_id), hold.id);
                  check("resp_err_hold", int'(bus.resp_err), hold.err);
               end
               if (bus.resp_ready) begin
                  model_busy = 0;
                  model_last = hold.id;
               end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].rcyc) begin
               check("resp_missing", int'(bus.resp_valid), 1);
               void'(exp_q.pop_front());
               model_busy = 0;
            end
            prev_rv = bus.resp_valid;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: got no finish, expected finish (cycle %0d)", cyc);
      $fatal(1, "simulation time limit");
   end

   // Main sequence
   initial begin
      int fair_exp[5];
      int n, m, r, l;
      fair_exp = '{0, 1, 2, 3, 0};

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check_reset_outputs("por");
      @(posedge clk); #1;
      reset = 1'b0;

      // fairness: all requesters held high
      sticky = '1;
      for (int i = 0; i < NREQ; i++) post(i, $urandom_range(0, 2), $urandom_range(0, 1), 2 + i);
      n = 0;
      while (grant_log.size() < 5 && n < 300) begin
         @(posedge clk); #2;
         n++;
      end
      sticky = '0;
      drain("fair_drain", 600);
      if (grant_log.size() >= 5) begin
         for (int k = 0; k < 5; k++) check($sformatf("rr_order%0d", k), grant_log[k], fair_exp[k]);
      end else begin
         fail_now("rr_order_count");
      end

      // single request, done 10 cycles after start
      post(2, 0, 0, 10);
      drain("single", 100);

      // watchdog, then a normal job
      post(1, 2, 1, 0);
      drain("watchdog", 200);
      post(1, 2, 1, 5);
      drain("after_watchdog", 100);

      // illegal mode
      post(3, 3, 0, 0);
      drain("illegal", 50);

      // backpressure with requester 0 pending
      rr_fixed = 1'b0;
      post(2, 1, 0, 5);
      n = 0;
      while (!bus.resp_valid && n < 100) begin
         @(posedge clk); #2;
         n++;
      end
      if (n >= 100) fail_now("bp_resp_wait");
      post(0, 0, 1, 4);
      repeat (20) @(posedge clk);
      #2;
      rr_fixed = 1'b1;
      drain("backpressure", 200);

      // watchdog boundaries
      post(0, 0, 0, TIMEOUT);
      drain("done_at_limit", 200);
      post(1, 1, 1, TIMEOUT + 1);
      drain("done_after_limit", 200);
      post(2, 2, 0, 1);
      drain("done_first_cycle", 100);

      // asynchronous reset in WAIT
      post(2, 0, 0, 0);
      n = 0;
      while (!bus.core_start && n < 50) begin
         @(posedge clk); #2;
         n++;
      end
      if (n >= 50) fail_now("rst_start_wait");
      repeat (5) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("mid_rst");
      #3;
      reset = 1'b0;
      post(3, 1, 0, 7);
      drain("after_reset", 100);

      // random jobs with random backpressure
      rr_rand = 1'b1;
      repeat (25) begin
         drain("rand_drain", 600);
         m = $urandom_range(1, (1 << NREQ) - 1);
         for (int i = 0; i < NREQ; i++) begin
            if (((m >> i) & 1) != 0) begin
               r = $urandom_range(0, 9);
               if (r == 0)      l = 0;
               else if (r == 1) l = TIMEOUT;
               else if (r == 2) l = TIMEOUT + 1;
               else             l = $urandom_range(1, 20);
               post(i, $urandom_range(0, 3), $urandom_range(0, 1), l);
            end
         end
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #2;
      end
      drain("rand_final", 600);
      rr_rand = 1'b0;
      repeat (3) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
